// File: rtl/step_pulse_gen_pkg.sv
// Shared command-word layout, widths and FSM encoding for the step/dir pulse generator.
package step_pkg;

    localparam int unsigned CMD_DIR_BIT = 31;
    localparam int unsigned CMD_H_MSB   = 30;
    localparam int unsigned CMD_H_LSB   = 16;
    localparam int unsigned CMD_N_MSB   = 15;
    localparam int unsigned CMD_N_LSB   = 0;

    localparam int unsigned H_WIDTH     = 15;
    localparam int unsigned N_WIDTH     = 16;
    localparam int unsigned SETUP_WIDTH = 8;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_HIGH  = 2'd2;
    localparam logic [1:0] S_LOW   = 2'd3;

    typedef struct packed {
        logic               dir;
        logic [H_WIDTH-1:0] half;
        logic [N_WIDTH-1:0] count;
    } cmd_t;

    // A zero half-period would stall the timer, so it is promoted to one clock.
    function automatic logic [H_WIDTH-1:0] half_eff(input logic [H_WIDTH-1:0] h);
        return (h == '0) ? H_WIDTH'(1) : h;
    endfunction

endpackage

// File: rtl/step_pulse_gen_if.sv
// Command/status bundle between the output register bank and the pulse generator.
interface step_pulse_gen_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] cmd_in;
    logic                  start_in;
    logic                  abort_in;
    logic                  step_out;
    logic                  dir_out;
    logic                  busy_out;
    logic                  done_out;
    logic [15:0]           steps_done_out;

    modport master (
        output cmd_in, start_in, abort_in,
        input  step_out, dir_out, busy_out, done_out, steps_done_out
    );

    modport slave (
        input  cmd_in, start_in, abort_in,
        output step_out, dir_out, busy_out, done_out, steps_done_out
    );
endinterface

// File: rtl/step_pulse_gen_timer.sv
// Loadable down-counter; tc_c flags the last cycle of a loaded interval.
module step_timer #(
    parameter int unsigned WIDTH = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             tc_c
);
    logic [WIDTH-1:0] count;

    // Count holds the cycles remaining in the interval, including the current one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign tc_c = (count == WIDTH'(1));

endmodule

// File: rtl/step_pulse_gen.sv
// STEP/DIR pulse-train generator: direction setup delay, then N pulses of programmable half-period.
module step_pulse_gen
    import step_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DIR_SETUP  = 4
) (
    input  logic             clk_in,
    input  logic             reset_in,
    step_pulse_gen_if.slave  bus
);

    logic [DATA_WIDTH-1:0] cmd_word;
    cmd_t                  cmd;

    logic [1:0]         state,      state_nxt;
    logic               step,       step_nxt;
    logic               dir,        dir_nxt;
    logic               busy,       busy_nxt;
    logic               done,       done_nxt;
    logic [N_WIDTH-1:0] steps_done, steps_done_nxt;
    logic [N_WIDTH-1:0] remaining,  remaining_nxt;
    logic [H_WIDTH-1:0] half,       half_nxt;

    logic setup_load_c;
    logic half_load_c;
    logic setup_tc_c;
    logic half_tc_c;

    assign cmd_word  = bus.cmd_in;
    assign cmd.dir   = cmd_word[CMD_DIR_BIT];
    assign cmd.half  = cmd_word[CMD_H_MSB:CMD_H_LSB];
    assign cmd.count = cmd_word[CMD_N_MSB:CMD_N_LSB];

    step_timer #(.WIDTH(SETUP_WIDTH)) u_setup_timer (
        .clk      (clk_in),
        .rst      (reset_in),
        .load     (setup_load_c),
        .load_val (SETUP_WIDTH'(DIR_SETUP)),
        .tc_c     (setup_tc_c)
    );

    step_timer #(.WIDTH(H_WIDTH)) u_half_timer (
        .clk      (clk_in),
        .rst      (reset_in),
        .load     (half_load_c),
        .load_val (half),
        .tc_c     (half_tc_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_nxt      = state;
        step_nxt       = step;
        dir_nxt        = dir;
        busy_nxt       = busy;
        done_nxt       = done;
        steps_done_nxt = steps_done;
        remaining_nxt  = remaining;
        half_nxt       = half;
        setup_load_c   = 1'b0;
        half_load_c    = 1'b0;

        if (state != S_IDLE && bus.abort_in) begin
            state_nxt = S_IDLE;
            step_nxt  = 1'b0;
            busy_nxt  = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start_in) begin
                        dir_nxt        = cmd.dir;
                        half_nxt       = half_eff(cmd.half);
                        remaining_nxt  = cmd.count;
                        steps_done_nxt = '0;
                        done_nxt       = (cmd.count == '0);
                        if (cmd.count != '0) begin
                            state_nxt    = S_SETUP;
                            busy_nxt     = 1'b1;
                            setup_load_c = 1'b1;
                        end
                    end
                end
                S_SETUP: begin
                    if (setup_tc_c) begin
                        state_nxt   = S_HIGH;
                        step_nxt    = 1'b1;
                        half_load_c = 1'b1;
                    end
                end
                S_HIGH: begin
                    if (half_tc_c) begin
                        state_nxt   = S_LOW;
                        step_nxt    = 1'b0;
                        half_load_c = 1'b1;
                    end
                end
                S_LOW: begin
                    // A step is credited at the end of its low phase.
                    if (half_tc_c) begin
                        steps_done_nxt = (steps_done == '1) ? steps_done
                                                             : steps_done + N_WIDTH'(1);
                        remaining_nxt  = remaining - N_WIDTH'(1);
                        if (remaining == N_WIDTH'(1)) begin
                            state_nxt = S_IDLE;
                            busy_nxt  = 1'b0;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt   = S_HIGH;
                            step_nxt    = 1'b1;
                            half_load_c = 1'b1;
                        end
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    step_nxt  = 1'b0;
                    busy_nxt  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state      <= S_IDLE;
            step       <= 1'b0;
            dir        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            steps_done <= '0;
            remaining  <= '0;
            half       <= '0;
        end else begin
            state      <= state_nxt;
            step       <= step_nxt;
            dir        <= dir_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            steps_done <= steps_done_nxt;
            remaining  <= remaining_nxt;
            half       <= half_nxt;
        end
    end

    assign bus.step_out       = step;
    assign bus.dir_out        = dir;
    assign bus.busy_out       = busy;
    assign bus.done_out       = done;
    assign bus.steps_done_out = steps_done;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Directed table-driven bench for step_pulse_gen with hand-written async-reset sequence.
module tb_step_pulse_gen;

    localparam int unsigned DIR_SETUP = 4;

    typedef struct {
        int unsigned rep;
        logic        start;
        logic        abort;
        logic [31:0] cmd;
        logic        step;
        logic        busy;
        logic        done;
        logic        dir;
        logic [15:0] steps;
    } vec_t;

    logic clk_in = 1'b0;
    logic reset_in;
    int   n_vec  = 0;
    int   n_miss = 0;
    vec_t vecs[$];

    step_pulse_gen_if #(.DATA_WIDTH(32)) bus ();

    step_pulse_gen #(.DATA_WIDTH(32), .DIR_SETUP(DIR_SETUP)) dut (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .bus      (bus)
    );

    always #5 clk_in = ~clk_in;

    function automatic void add(input int unsigned rep, input logic start, input logic abort,
                                input logic [31:0] cmd, input logic step, input logic busy,
                                input logic done, input logic dir, input logic [15:0] steps);
        vec_t v;
        v.rep = rep; v.start = start; v.abort = abort; v.cmd = cmd;
        v.step = step; v.busy = busy; v.done = done; v.dir = dir; v.steps = steps;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic step, input logic busy,
                         input logic done, input logic dir, input logic [15:0] steps);
        n_vec++;
        if (bus.step_out !== step || bus.busy_out !== busy || bus.done_out !== done ||
            bus.dir_out !== dir || bus.steps_done_out !== steps) begin
            n_miss++;
            $display("FAIL %s: got step=%b busy=%b done=%b dir=%b steps=%0d, want step=%b busy=%b done=%b dir=%b steps=%0d",
                     name, bus.step_out, bus.busy_out, bus.done_out, bus.dir_out,
                     bus.steps_done_out, step, busy, done, dir, steps);
        end
    endtask

    initial begin
        logic found;

        // Row r: inputs held during the cycle, expected outputs just after the closing edge.
        // Normal run dir=1 H=2 N=3, with an ignored start (dir=0) during the LOW phase.
        add(1, 1, 0, 32'h8002_0003, 0, 1, 0, 1, 0);
        add(3, 0, 0, 32'h8002_0003, 0, 1, 0, 1, 0);
        add(2, 0, 0, 32'h8002_0003, 1, 1, 0, 1, 0);
        add(2, 1, 0, 32'h0001_0010, 0, 1, 0, 1, 0);
        add(2, 0, 0, 32'h8002_0003, 1, 1, 0, 1, 1);
        add(2, 0, 0, 32'h8002_0003, 0, 1, 0, 1, 1);
        add(2, 0, 0, 32'h8002_0003, 1, 1, 0, 1, 2);
        add(2, 0, 0, 32'h8002_0003, 0, 1, 0, 1, 2);
        add(1, 0, 0, 32'h8002_0003, 0, 0, 1, 1, 3);
        add(2, 0, 0, 32'h8002_0003, 0, 0, 1, 1, 3);
        // Restart with H=0 (acts as H=1), N=2: busy 8 cycles; clears done/steps, dir -> 0.
        add(1, 1, 0, 32'h0000_0002, 0, 1, 0, 0, 0);
        add(1, 0, 0, 32'h0000_0002, 0, 1, 0, 0, 0);
        add(1, 1, 0, 32'h0001_0010, 0, 1, 0, 0, 0);
        add(1, 0, 0, 32'h0000_0002, 0, 1, 0, 0, 0);
        add(1, 0, 0, 32'h0000_0002, 1, 1, 0, 0, 0);
        add(1, 0, 0, 32'h0000_0002, 0, 1, 0, 0, 0);
        add(1, 0, 0, 32'h0000_0002, 1, 1, 0, 0, 1);
        add(1, 0, 0, 32'h0000_0002, 0, 1, 0, 0, 1);
        add(1, 0, 0, 32'h0000_0002, 0, 0, 1, 0, 2);
        // Abort during the second HIGH of a normal run, then abort while idle.
        add(1, 1, 0, 32'h8002_0003, 0, 1, 0, 1, 0);
        add(3, 0, 0, 32'h8002_0003, 0, 1, 0, 1, 0);
        add(2, 0, 0, 32'h8002_0003, 1, 1, 0, 1, 0);
        add(2, 0, 0, 32'h8002_0003, 0, 1, 0, 1, 0);
        add(1, 0, 0, 32'h8002_0003, 1, 1, 0, 1, 1);
        add(1, 0, 1, 32'h8002_0003, 0, 0, 0, 1, 1);
        add(2, 0, 0, 32'h8002_0003, 0, 0, 0, 1, 1);
        add(1, 0, 1, 32'h8002_0003, 0, 0, 0, 1, 1);
        // N=0 command: no pulses, done immediately, dir follows command.
        add(1, 1, 0, 32'h0005_0000, 0, 0, 1, 0, 0);
        add(2, 0, 0, 32'h0005_0000, 0, 0, 1, 0, 0);
        // Start and abort together in IDLE: start wins (H=1, N=1).
        add(1, 1, 1, 32'h0001_0001, 0, 1, 0, 0, 0);
        add(3, 0, 0, 32'h0001_0001, 0, 1, 0, 0, 0);
        add(1, 0, 0, 32'h0001_0001, 1, 1, 0, 0, 0);
        add(1, 0, 0, 32'h0001_0001, 0, 1, 0, 0, 0);
        add(1, 0, 0, 32'h0001_0001, 0, 0, 1, 0, 1);

        reset_in     = 1'b1;
        bus.cmd_in   = '0;
        bus.start_in = 1'b0;
        bus.abort_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1 reset_in = 1'b0;
        check("reset_state", 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            for (int r = 0; r < int'(vecs[i].rep); r++) begin
                bus.start_in = vecs[i].start;
                bus.abort_in = vecs[i].abort;
                bus.cmd_in   = vecs[i].cmd;
                @(posedge clk_in);
                #1;
                check($sformatf("vec%0d_%0d", i, r), vecs[i].step, vecs[i].busy,
                      vecs[i].done, vecs[i].dir, vecs[i].steps);
            end
        end
        bus.start_in = 1'b0;
        bus.abort_in = 1'b0;

        // Async reset while STEP is high.
        bus.cmd_in   = 32'h8002_0003;
        bus.start_in = 1'b1;
        @(posedge clk_in);
        #1 bus.start_in = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(posedge clk_in);
            #1;
            if (bus.step_out === 1'b1) found = 1'b1;
        end
        n_vec++;
        if (!found) begin
            n_miss++;
            $display("FAIL wait_step_high: step_out=%b after 20 cycles, want 1", bus.step_out);
        end
        #2 reset_in = 1'b1;
        #1 check("async_reset_mid_high", 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk_in);
        #1 reset_in = 1'b0;
        check("after_reset_release", 0, 0, 0, 0, 0);
        repeat (12) @(posedge clk_in);
        #1 check("no_pulse_after_reset", 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/step_pulse_gen.md
Name: step_pulse_gen

Overview:
- Motion stage directly downstream of the memory-mapped output register.
- Consumes the 32-bit command word the register drives on its mem_out bus, plus a one-cycle start strobe.
- Emits a STEP/DIR pulse train for the external stepper driver: N step pulses, programmable half-period, with direction setup time before the first edge.
- Reports busy, done and the count of steps issued back to the register bank.

Parameters:
- DATA_WIDTH, 32, width of cmd_in; must be 32 (field layout below is fixed).
- DIR_SETUP, 4, clock cycles between a dir_out update and the first step_out rising edge; legal range 1..255.

Ports:
- clk_in  input  1  system clock
- reset_in  input  1  asynchronous, active-high reset
- cmd_in  input  DATA_WIDTH  command word from the output register: [31] direction, [30:16] half-period H in clocks, [15:0] step count N
- start_in  input  1  one-cycle strobe; command is sampled on the clk_in edge where start_in=1; the register bank asserts it one cycle after its write
- abort_in  input  1  stop the pulse train immediately
- step_out  output  1  STEP pin
- dir_out  output  1  DIR pin
- busy_out  output  1  pulse train in progress
- done_out  output  1  sticky completion flag
- steps_done_out  output  16  steps completed since the last accepted start

Behaviour:
- Reset (async, active-high): state IDLE; step_out=0, dir_out=0, busy_out=0, done_out=0, steps_done_out=0; all counters cleared.
- Reset mid-train: step_out drops asynchronously and no further pulse is emitted.
- States: IDLE, SETUP, HIGH, LOW.
- IDLE:
  - start_in=1 at edge k latches dir, H_eff = (H==0 ? 1 : H) and N.
  - It clears done_out and steps_done_out and updates dir_out at k+1.
  - If N!=0: state SETUP, busy_out=1 at k+1.
  - If N==0: stay IDLE, busy_out stays 0, done_out=1 at k+1.
- SETUP: lasts exactly DIR_SETUP cycles, then HIGH.
  - The first step_out rising edge is at k+1+DIR_SETUP.
- HIGH: step_out=1 for H_eff cycles, then LOW.
- LOW: step_out=0 for H_eff cycles.
  - On its last cycle, steps_done_out increments (saturates at 65535, unreachable in practice) and the remaining count decrements.
  - If remaining becomes 0: IDLE, busy_out=0, done_out=1. Otherwise HIGH.
- Total busy time = DIR_SETUP + 2*H_eff*N cycles. busy_out falls and done_out rises on the same edge, k+1+DIR_SETUP+2*H_eff*N.
- Registered outputs: step_out is a direct register output (glitch-free). dir_out changes only in IDLE→SETUP or on an N==0 start, never while step_out=1.
- start_in while busy: ignored; the latched command and the counters are unchanged.
- abort_in (any non-IDLE state): next edge → IDLE, step_out=0, busy_out=0, done_out stays 0, steps_done_out keeps its value.
  - abort_in in IDLE has no effect.
  - abort_in and start_in in the same IDLE cycle: start wins.
- done_out stays 1 until the next accepted start_in or reset.
- Arithmetic widths:
  - Half-period counter: 15 bits.
  - Step down-counter and steps_done_out: 16 bits.
  - Setup counter: 8 bits.
  - No wrap-around is possible within legal ranges.

Decomposition:
- Shared package (step_pkg): field positions CMD_DIR_BIT=31, CMD_H_MSB=30, CMD_H_LSB=16, CMD_N_MSB=15, CMD_N_LSB=0; state encoding localparams S_IDLE/S_SETUP/S_HIGH/S_LOW.
- Single sub-module: step_timer, a loadable down-counter with a terminal-count flag. It is reused for the SETUP and half-period timing.
- The FSM and step counter live in step_pulse_gen.

Test Plan:
- Reset check: assert reset_in mid-HIGH → step_out=0 and busy_out=0 immediately (async). After release, all outputs are 0.
- Normal run: DIR_SETUP=4, cmd_in=0x8002_0003 (dir=1, H=2, N=3), start at edge 0.
  - dir_out=1 and busy_out=1 at edge 1.
  - step_out high on edges 5-6, 9-10, 13-14.
  - busy_out=0, done_out=1, steps_done_out=3 at edge 17.
- Zero/degenerate commands:
  - cmd_in=0x0005_0000 (N=0) → no step pulses, busy_out stays 0, done_out=1 at edge 1.
  - cmd_in=0x0000_0002 (H=0) → behaves as H=1: busy for 4+4=8 cycles.
- Start while busy: second start_in with cmd_in=0x0001_0010 during the run → ignored. Original 3 pulses only; dir_out is unchanged.
- Abort: abort_in during the second HIGH of the normal run → step_out=0 and busy_out=0 next edge, done_out=0, steps_done_out=1.
- Restart after done: a new start clears done_out to 0 and steps_done_out to 0 at edge k+1. dir_out toggles to the new value before any step edge.
